// File: rtl/pwm_pkg.sv
// Shared types and widths for the PWM scanner and its threshold memory.
package pwm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pwm_state_t;

    localparam int PWM_WIDTH = 16;
    localparam int NUM_PWM   = 4;

endpackage

// File: rtl/pwm_slot_counter.sv
// Channel/count slot counter: chan steps every clock, cnt steps on chan wrap.
module pwm_slot_counter
    import pwm_pkg::*;
#(
    parameter int pwm_width = PWM_WIDTH,
    parameter int num_pwm   = NUM_PWM
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       clr,
    output logic [$clog2(num_pwm)-1:0] chan,
    output logic [pwm_width-1:0]       cnt,
    output logic                       last_chan,
    output logic                       last_slot,
    output logic                       first_slot
);

    localparam int AW = $clog2(num_pwm);
    localparam logic [AW-1:0] CHAN_MAX = AW'(num_pwm - 1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            chan <= '0;
            cnt  <= '0;
        end else if (en) begin
            if (last_chan) begin
                chan <= '0;
                cnt  <= cnt + 1'b1;
            end else begin
                chan <= chan + 1'b1;
            end
        end
    end

    always_comb begin
        last_chan  = (chan == CHAN_MAX);
        last_slot  = last_chan && (&cnt);
        first_slot = (chan == '0) && (cnt == '0);
    end

endmodule

// File: rtl/pwm_scanner.sv
// Time-multiplexed PWM scanner over a single-port threshold memory.
// Define PWM_SCANNER_SYNC_OUT_EN to update all outputs together per count step.
module pwm_scanner
    import pwm_pkg::*;
#(
    parameter int pwm_width = PWM_WIDTH,
    parameter int num_pwm   = NUM_PWM
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    output logic [$clog2(num_pwm)-1:0] raddr,
    input  logic [pwm_width-1:0]       rdata,
    output logic                       latch_mem,
    output logic                       period_start,
    output logic [num_pwm-1:0]         pwm_out
);

    localparam int AW = $clog2(num_pwm);

    pwm_state_t state;
    pwm_state_t state_next;

    logic                 active;
    logic [AW-1:0]        chan;
    logic [pwm_width-1:0] cnt;
    logic                 last_chan;
    logic                 last_slot;
    logic                 first_slot;
    logic                 level;

    pwm_slot_counter #(
        .pwm_width(pwm_width),
        .num_pwm  (num_pwm)
    ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .en        (active),
        .clr       (!active),
        .chan      (chan),
        .cnt       (cnt),
        .last_chan (last_chan),
        .last_slot (last_slot),
        .first_slot(first_slot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (enable)  state_next = RUN;
            RUN:  if (!enable) state_next = IDLE;
        endcase
    end

    // Dropping enable on the last slot must not swap the memory bank.
    always_comb begin
        active       = (state == RUN) && enable;
        raddr        = (state == RUN) ? chan : '0;
        latch_mem    = active && last_slot;
        period_start = (state == RUN) && first_slot;
    end

    assign level = (cnt < rdata);

`ifdef PWM_SCANNER_SYNC_OUT_EN
    logic [num_pwm-1:0] staging;
    logic [num_pwm-1:0] merged;

    always_comb begin
        merged       = staging;
        merged[chan] = level;
    end

    always_ff @(posedge clk) begin
        if (rst || !active) begin
            staging <= '0;
            pwm_out <= '0;
        end else begin
            staging[chan] <= level;
            if (last_chan) begin
                pwm_out <= merged;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst || !active) begin
            pwm_out <= '0;
        end else begin
            pwm_out[chan] <= level;
        end
    end
`endif

endmodule
